uart_recv: RTL and testbench



---
 rtl/uart_recv.sv | 154 +++++++++++++++
 tb/tb_uart_recv.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// uart_recv: single-clock UART receiver.
// Frame: start (0), 8 data bits, stop (1); line idles high.
// The line is resynchronised and then sampled at mid-bit using a cycle
// counter. Bytes are delivered through a rdy/rd_ack handshake. Framing
// errors and overruns are reported as single-cycle pulses.
module uart_recv #(
    parameter int CLKS_PER_BIT = 16,  // even, >= 4
    parameter bit MSB_FIRST    = 1'b1 // 1: first data bit lands in data_out[7]
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    input  logic       rd_ack,
    output logic [7:0] data_out,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // Terminal counts: half a bit to reach mid-start, a full bit thereafter.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_nxt;
    logic          sync_q1;  // first synchroniser stage
    logic          rs;       // synchronised rxd, the only view of the line
    logic          rs_prev;  // rs one cycle ago, for falling-edge detection
    logic [CW-1:0] cyc_cnt, cyc_nxt;
    logic [3:0]    bit_cnt, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          byte_done;  // good stop bit sampled this cycle
    logic          stop_bad;   // stop bit sampled low this cycle

    // Two-flop synchroniser plus edge-history flop; reset to idle-high so a
    // reset release never looks like a start edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= 1'b1;
            rs      <= 1'b1;
            rs_prev <= 1'b1;
        end else begin
            sync_q1 <= rxd;
            rs      <= sync_q1;
            rs_prev <= rs;
        end
    end

    // FSM state, counters and shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
        end
    end

    // Next-state logic: every sample point is a counter terminal count.
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt + CW'(1);
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        unique case (state)
            IDLE: begin
                cyc_nxt = '0;
                if (rs_prev && !rs) state_nxt = START;
            end
            START: begin
                // Mid start bit: a line back high means the fall was a glitch.
                if (cyc_cnt == HALF_M1) begin
                    cyc_nxt = '0;
                    if (rs) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        bit_nxt   = 4'd0;
                    end
                end
            end
            DATA: begin
                if (cyc_cnt == FULL_M1) begin
                    cyc_nxt   = '0;
                    shift_nxt = MSB_FIRST ? {shift[6:0], rs} : {rs, shift[7:1]};
                    if (bit_cnt == 4'd7) state_nxt = STOP;
                    else                 bit_nxt   = bit_cnt + 4'd1;
                end
            end
            STOP: begin
                // Return to IDLE straight after mid-stop so the next start
                // edge can be caught without an extra idle gap.
                if (cyc_cnt == FULL_M1) begin
                    cyc_nxt = '0;
                    if (rs) begin
                        byte_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low (break) line must go high before a new start.
                cyc_nxt = '0;
                if (rs) state_nxt = IDLE;
            end
            default: begin
                cyc_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Output registers: byte delivery, handshake and status pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out  <= 8'h00;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            // An ack in the landing cycle consumes the old byte, so no overrun.
            overrun   <= byte_done && rdy && !rd_ack;
            busy      <= (state_nxt != IDLE);
            if (byte_done) begin
                data_out <= shift;
                rdy      <= 1'b1;
            end else if (rd_ack) begin
                rdy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv: an MSB-first and an LSB-first instance share
// the line; frame vectors come from a table, corner cases are hand-sequenced.
module tb_uart_recv;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] data_a, data_b;
    logic       rdy_a, rdy_b, ferr_a, ferr_b, ovr_a, ovr_b, busy_a, busy_b;

    int n_chk = 0;
    int n_pass = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;

    uart_recv #(.CLKS_PER_BIT(16), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .resetn(resetn), .rxd(rxd), .rd_ack(rd_ack),
        .data_out(data_a), .rdy(rdy_a), .frame_err(ferr_a),
        .overrun(ovr_a), .busy(busy_a)
    );

    uart_recv #(.CLKS_PER_BIT(16), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .resetn(resetn), .rxd(rxd), .rd_ack(rd_ack),
        .data_out(data_b), .rdy(rdy_b), .frame_err(ferr_b),
        .overrun(ovr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Pulse counters for the MSB-first instance.
    always @(negedge clk) begin
        if (ferr_a) ferr_cnt <= ferr_cnt + 1;
        if (ovr_a)  ovr_cnt  <= ovr_cnt + 1;
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[8 - idx];
        return stop;
    endfunction

    // One 160-clk frame starting at the current negedge; rd_ack high for the
    // single cycle starting at negedge offset ack_at (-1: never).
    task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at);
        for (int k = 0; k < 160; k++) begin
            if (k % 16 == 0) rxd = frame_bit(b, stop, k / 16);
            rd_ack = (k == ack_at);
            @(negedge clk);
        end
        rd_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    initial begin
        vec_t vecs[4];
        int   first, f0, o0, bcnt;

        vecs[0] = '{tx: 8'hA5, exp_a: 8'hA5, exp_b: 8'hA5};
        vecs[1] = '{tx: 8'h12, exp_a: 8'h12, exp_b: 8'h48};
        vecs[2] = '{tx: 8'hC0, exp_a: 8'hC0, exp_b: 8'h03};
        vecs[3] = '{tx: 8'h01, exp_a: 8'h01, exp_b: 8'h80};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset data_out", data_a, 8'h00);
        chk("reset rdy", rdy_a, 0);
        chk("reset frame_err", ferr_a, 0);
        chk("reset overrun", ovr_a, 0);
        chk("reset busy", busy_a, 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Latency: rdy first seen 155 clk after the rxd fall
        rxd = 1'b0;
        first = -1;
        for (int k = 1; k <= 170; k++) begin
            @(negedge clk);
            if (rdy_a && first < 0) first = k;
            rxd = (k < 160) ? frame_bit(8'hA5, 1'b1, k / 16) : 1'b1;
        end
        chk("rdy latency", first, 155);
        chk("A5 data msb", data_a, 8'hA5);
        chk("A5 data lsb", data_b, 8'hA5);
        chk("A5 no frame_err", ferr_cnt, 0);
        ack_pulse();
        chk("rdy cleared by ack", rdy_a, 0);

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            send_frame(vecs[i].tx, 1'b1, -1);
            chk($sformatf("vec%0d data msb", i), data_a, vecs[i].exp_a);
            chk($sformatf("vec%0d data lsb", i), data_b, vecs[i].exp_b);
            chk($sformatf("vec%0d rdy", i), rdy_a, 1);
            ack_pulse();
            chk($sformatf("vec%0d rdy after ack", i), rdy_a, 0);
            chk($sformatf("vec%0d frame_err", i), ferr_cnt - f0, 0);
            chk($sformatf("vec%0d overrun", i), ovr_cnt - o0, 0);
        end

        // Back-to-back without ack: overrun once
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        chk("b2b data", data_a, 8'h22);
        chk("b2b rdy", rdy_a, 1);
        chk("b2b overrun count", ovr_cnt - o0, 1);
        ack_pulse();

        // Back-to-back with ack on the landing cycle: no overrun
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, 154);
        chk("ack-land data", data_a, 8'h22);
        chk("ack-land rdy", rdy_a, 1);
        chk("ack-land overrun count", ovr_cnt - o0, 0);
        ack_pulse();
        chk("ack-land rdy cleared", rdy_a, 0);

        // Framing error followed by a held-low line
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1);
        repeat (40) @(negedge clk);
        chk("break busy", busy_a, 1);
        chk("break frame_err count", ferr_cnt - f0, 1);
        chk("break rdy", rdy_a, 0);
        chk("break data kept", data_a, 8'h22);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        chk("break busy released", busy_a, 0);
        bcnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy_a) bcnt++;
        end
        chk("break no second frame", bcnt, 0);
        chk("break rdy stays 0", rdy_a, 0);

        // 5-clk glitch: false start, busy for 8 clk
        f0 = ferr_cnt;
        bcnt = 0;
        rxd = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy_a) bcnt++;
            if (k == 5) rxd = 1'b1;
        end
        chk("glitch busy cycles", bcnt, 8);
        chk("glitch rdy", rdy_a, 0);
        chk("glitch frame_err", ferr_cnt - f0, 0);

        // Leave a byte unread, then reset at data bit 4 of a 0xFF frame
        send_frame(8'h5A, 1'b1, -1);
        chk("pre-reset data", data_a, 8'h5A);
        chk("pre-reset rdy", rdy_a, 1);
        for (int k = 0; k < 88; k++) begin
            if (k % 16 == 0) rxd = frame_bit(8'hFF, 1'b1, k / 16);
            @(negedge clk);
        end
        chk("mid-frame busy", busy_a, 1);
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        resetn = 1'b0;
        #1;
        chk("async reset data", data_a, 8'h00);
        chk("async reset rdy", rdy_a, 0);
        chk("async reset busy", busy_a, 0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h81, 1'b1, -1);
        chk("post-reset data msb", data_a, 8'h81);
        chk("post-reset data lsb", data_b, 8'h81);
        chk("post-reset rdy", rdy_a, 1);
        chk("post-reset frame_err", ferr_cnt - f0, 0);
        chk("post-reset overrun", ovr_cnt - o0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
